// File: rtl/uarch.sv
// Shared micro-architecture types for the core.
// word is the native operand width; dword holds double-width multiply results.
package uarch;

    typedef logic [31:0] word;
    typedef logic [63:0] dword;

    // Magnitude of a two's-complement word; 0x80000000 maps to 2^31 unsigned.
    function automatic word to_magnitude(input word value, input logic is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/core_mul.sv
// Iterative shift-and-add multiplier / multiply-accumulate unit.
// Handles MUL, MLA, UMULL, SMULL, UMLAL and SMLAL, one multiplier bit per cycle.
module core_mul
    import uarch::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    input  logic [31:0] mul_c_hi,
    input  logic [31:0] mul_c_lo,
    input  logic        mul_add,
    input  logic        mul_long,
    input  logic        mul_signed,
    input  logic        mul_start,
    output logic        mul_ready,
    output logic [31:0] mul_q_hi,
    output logic [31:0] mul_q_lo
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FIX,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    dword       mcand_q, mcand_d;
    word        mplier_q, mplier_d;
    dword       prod_q, prod_d;
    dword       acc_q, acc_d;
    logic       neg_q, neg_d;
    logic       long_q, long_d;
    word        q_hi_q, q_hi_d;
    word        q_lo_q, q_lo_d;

    logic       load;
    logic       sign_ops;
    dword       signed_prod;
    dword       fix_sum;

    // Signed long ops run on magnitudes; the sign is restored in FIX.
    assign sign_ops    = mul_long && mul_signed;
    assign load        = mul_start && ((state_q == IDLE) || (state_q == DONE));
    assign signed_prod = neg_q ? (~prod_q + 64'd1) : prod_q;
    assign fix_sum     = signed_prod + acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        long_d   = long_q;
        q_hi_d   = q_hi_q;
        q_lo_d   = q_lo_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                q_hi_d  = long_q ? fix_sum[63:32] : 32'd0;
                q_lo_d  = fix_sum[31:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = load ? MUL : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            mcand_d  = {32'd0, to_magnitude(mul_a, sign_ops)};
            mplier_d = to_magnitude(mul_b, sign_ops);
            prod_d   = 64'd0;
            cnt_d    = 5'd0;
            neg_d    = sign_ops && (mul_a[31] ^ mul_b[31]);
            long_d   = mul_long;
            if (!mul_add) begin
                acc_d = 64'd0;
            end else if (mul_long) begin
                acc_d = {mul_c_hi, mul_c_lo};
            end else begin
                acc_d = {32'd0, mul_c_lo};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            acc_q    <= 64'd0;
            neg_q    <= 1'b0;
            long_q   <= 1'b0;
            q_hi_q   <= 32'd0;
            q_lo_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            long_q   <= long_d;
            q_hi_q   <= q_hi_d;
            q_lo_q   <= q_lo_d;
        end
    end

    assign mul_ready = (state_q == DONE);
    assign mul_q_hi  = q_hi_q;
    assign mul_q_lo  = q_lo_q;

endmodule

// File: tb/tb_core_mul.sv
// Self-checking bench for core_mul: arithmetic reference model with a per-cycle
// compare process, plus directed vectors with hand-computed results.
module tb_core_mul;

    logic        clk;
    logic        rst;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_c_hi;
    logic [31:0] mul_c_lo;
    logic        mul_add;
    logic        mul_long;
    logic        mul_signed;
    logic        mul_start;
    logic        mul_ready;
    logic [31:0] mul_q_hi;
    logic [31:0] mul_q_lo;

    int checks = 0;
    int errors = 0;

    core_mul dut (
        .clk        (clk),
        .rst        (rst),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c_hi   (mul_c_hi),
        .mul_c_lo   (mul_c_lo),
        .mul_add    (mul_add),
        .mul_long   (mul_long),
        .mul_signed (mul_signed),
        .mul_start  (mul_start),
        .mul_ready  (mul_ready),
        .mul_q_hi   (mul_q_hi),
        .mul_q_lo   (mul_q_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from (a*b + C) mod 2^64.
    function automatic logic [63:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [31:0] c_hi, input logic [31:0] c_lo,
                                                 input logic add, input logic lng, input logic sgn);
        logic [63:0] p;
        logic [63:0] c;
        longint      sa;
        longint      sb;
        if (lng && sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        if (!add)     c = 64'd0;
        else if (lng) c = {c_hi, c_lo};
        else          c = {32'd0, c_lo};
        p = p + c;
        if (!lng) p[63:32] = 32'd0;
        return p;
    endfunction

    // Timing model: an accepted op produces ready 34 cycles after its start edge.
    int          remain;
    logic [63:0] pending;
    logic [63:0] exp_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            remain = 0;
            exp_q  = 64'd0;
        end else if (remain <= 1 && mul_start) begin
            remain  = 34;
            pending = model_result(mul_a, mul_b, mul_c_hi, mul_c_lo, mul_add, mul_long, mul_signed);
        end else if (remain > 0) begin
            remain = remain - 1;
            if (remain == 1) exp_q = pending;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_val("cyc_ready", {63'd0, mul_ready}, {63'd0, remain == 1});
            check_val("cyc_q", {mul_q_hi, mul_q_lo}, exp_q);
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c_hi,
                            input logic [31:0] c_lo, input logic add, input logic lng, input logic sgn);
        mul_a      = a;
        mul_b      = b;
        mul_c_hi   = c_hi;
        mul_c_lo   = c_lo;
        mul_add    = add;
        mul_long   = lng;
        mul_signed = sgn;
        mul_start  = 1'b1;
        @(negedge clk);
        mul_start  = 1'b0;
        mul_a      = $urandom;
        mul_b      = $urandom;
        mul_c_hi   = $urandom;
        mul_c_lo   = $urandom;
        mul_add    = 1'($urandom);
        mul_long   = 1'($urandom);
        mul_signed = 1'($urandom);
    endtask

    task automatic wait_ready(input string name);
        int cycles;
        cycles = 1;
        while (!mul_ready && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check_val(name, 64'(cycles), 64'd34);
    endtask

    task automatic check_output(input string name, input logic [63:0] exp);
        check_val({name, "_dut"}, {mul_q_hi, mul_q_lo}, exp);
        check_val({name, "_model"}, exp_q, exp);
    endtask

    task automatic apply_stimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c_hi, input logic [31:0] c_lo, input logic add,
                                  input logic lng, input logic sgn, input logic [63:0] exp);
        start_op(a, b, c_hi, c_lo, add, lng, sgn);
        wait_ready({name, "_lat"});
        check_output(name, exp);
        @(negedge clk);
    endtask

    int ready_count;

    initial begin
        rst        = 1'b1;
        mul_a      = 32'd0;
        mul_b      = 32'd0;
        mul_c_hi   = 32'd0;
        mul_c_lo   = 32'd0;
        mul_add    = 1'b0;
        mul_long   = 1'b0;
        mul_signed = 1'b0;
        mul_start  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("reset_ready", {63'd0, mul_ready}, 64'd0);
        check_val("reset_q", {mul_q_hi, mul_q_lo}, 64'd0);

        apply_stimulus("mul", 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd42);
        apply_stimulus("mla", 32'hFFFF_FFFF, 32'd2, 32'hDEAD_BEEF, 32'd5, 1'b1, 1'b0, 1'b1,
                       64'h0000_0000_0000_0003);
        apply_stimulus("umull", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0,
                       64'hFFFF_FFFE_0000_0001);
        apply_stimulus("smull_edge", 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1,
                       64'h0000_0000_8000_0000);
        apply_stimulus("smlal", 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10, 1'b1, 1'b1, 1'b1, 64'd4);
        apply_stimulus("umlal", 32'h8000_0000, 32'd4, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0,
                       64'h0000_0003_FFFF_FFFF);
        apply_stimulus("smull_neg", 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1,
                       64'hFFFF_FFFF_8000_0000);

        // A start pulse while busy must be dropped, not queued.
        start_op(32'd100, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        start_op(32'd5, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        ready_count = 0;
        for (int i = 0; i < 80; i++) begin
            if (mul_ready) begin
                ready_count++;
                check_output("busy_result", 64'd300);
            end
            @(negedge clk);
        end
        check_val("busy_ready_count", 64'(ready_count), 64'd1);

        // Back-to-back: start held in the DONE cycle.
        start_op(32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        wait_ready("b2b_first_lat");
        check_output("b2b_first", 64'd81);
        start_op(32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        wait_ready("b2b_second_lat");
        check_output("b2b_second", 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk);

        // Reset in the middle of MUL aborts the operation.
        start_op(32'd1234, 32'd5678, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_ready", {63'd0, mul_ready}, 64'd0);
        check_val("abort_q", {mul_q_hi, mul_q_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ready_count = 0;
        for (int i = 0; i < 50; i++) begin
            if (mul_ready) ready_count++;
            @(negedge clk);
        end
        check_val("abort_ready_count", 64'(ready_count), 64'd0);
        check_val("abort_q_after", {mul_q_hi, mul_q_lo}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
